obi_host_mailbox: RTL
=====================

Name: obi_host_mailbox

Overview:
- Parametrised successor to the single-register host/X-HEEP bridge.
- Sits between the USB register block (host side) and the gr_heep_top OBI slave port (req/we/be/addr/wdata -> gnt/rvalid/rdata).
- Replaces the one-deep instruction latch with a command FIFO, adds a HEEP-to-host response FIFO, sticky error flags and a per-flag clear vector.
- Removes the external status-clear mux: flag clearing is internal.

Parameters:
- pDATA_WIDTH, 32: command, response, OBI data and section-address width.
- pCMD_DEPTH, 8: command FIFO entries; power of 2, minimum 2.
- pRSP_DEPTH, 4: response FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock; HEEP clock domain. Host inputs are already synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- host_cmd_wr  in  1  push host_cmd_data into the command FIFO.
- host_cmd_data  in  pDATA_WIDTH  command word.
- host_addr_wr  in  1  latch host_addr_data as the new section address.
- host_addr_data  in  pDATA_WIDTH  section address.
- host_rsp_rd  in  1  pop the response FIFO.
- host_rsp_data  out  pDATA_WIDTH  response FIFO head; 0 when empty.
- host_flag_clr  in  4  one-cycle clear strobes, one per flag (see Behaviour).
- status  out  8  status vector.
- req  in  1  OBI request.
- we  in  1  OBI write enable.
- be  in  4  OBI byte enables.
- addr  in  32  OBI address; only addr[4:2] is decoded.
- wdata  in  32  OBI write data.
- gnt  out  1  OBI grant.
- rvalid  out  1  OBI response valid.
- rdata  out  32  OBI read data.

Behaviour:
- Reset: FIFOs empty, pointers and counts 0, section address 0, all flags 0. Outputs after reset: rvalid=0, rdata=0, host_rsp_data=0, status=8'h01 (cmd_empty=1).
- Status bits:
  - [0] cmd_empty, [1] cmd_full, [2] addr_valid, [3] rsp_nonempty, [4] rsp_full: live.
  - [5] cmd_overflow, [6] cmd_underflow, [7] rsp_overflow: sticky.
- Clear vector: host_flag_clr[0] clears bit5, [1] clears bit6, [2] clears bit7, [3] clears addr_valid. A set event in the same cycle as its clear wins (flag stays 1).
- OBI handshake:
  - gnt = req (combinational; always granted).
  - Every granted request produces rvalid=1 exactly one cycle later, reads and writes alike. Back-to-back requests are accepted every cycle.
  - rdata is registered. It holds read data with rvalid, is 0 for writes, and is 0 when rvalid=0.
- OBI map (addr[4:2]):
  - 0 CMD_POP (R): returns the command FIFO head and pops it. If empty, returns 0 and sets cmd_underflow.
  - 1 SECTION_ADDR (R): returns the section address and clears addr_valid.
  - 2 STATUS (R): returns {24'b0, status}.
  - 3 RSP_PUSH (W): pushes wdata with byte lanes where be=0 forced to 0. If the response FIFO is full, the word is dropped and rsp_overflow is set.
  - 4 CMD_COUNT (R): returns the command occupancy, zero-extended.
  - All other offsets, and writes to read-only offsets: write ignored, read returns 0, rvalid still issued.
- Command FIFO:
  - Occupancy counter is clog2(pCMD_DEPTH)+1 bits; pointers wrap modulo depth.
  - host_cmd_wr when full and no pop in the same cycle: word dropped, cmd_overflow set.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: pop underflows (returns 0, flag set), push is stored, count becomes 1. There is no bypass.
- Section address:
  - host_addr_wr latches the data and sets addr_valid. This overwrites any unread value; no error is flagged.
  - host_addr_wr in the same cycle as a SECTION_ADDR read: the read returns the old value, the new value is latched, and addr_valid ends at 1.
- Response FIFO:
  - host_rsp_data is combinational from the head entry.
  - host_rsp_rd when empty is ignored.
  - Push and pop in the same cycle when full: both take effect, no overflow.
- Reset mid-operation: a pending rvalid is cancelled and FIFO contents are discarded. The HEEP side must reissue requests.

Test Plan:
1. Reset, then read STATUS -> rdata=32'h01 one cycle after gnt; rvalid high for exactly 1 cycle.
2. Host pushes 32'hA0..32'hA7 (depth 8), then a 9th word 32'hFF -> status=8'h22 (full and overflow set). Eight CMD_POP reads return A0..A7 in order. A 9th CMD_POP returns 0 and status bit6=1. host_flag_clr=4'b0011 -> status=8'h01.
3. With the command FIFO full, host_cmd_wr and CMD_POP in the same cycle -> CMD_COUNT reads 8, no overflow, and the pushed word is popped last.
4. host_addr_wr 32'h0000_1000 -> status bit2=1. SECTION_ADDR read returns 32'h1000 and bit2 drops to 0. A repeat read issued in the same cycle as host_addr_wr 32'h2000 returns 32'h1000, and bit2 ends at 1.
5. RSP_PUSH wdata=32'h1122_3344, be=4'b0101 -> host_rsp_data=32'h0022_0044. Five pushes (depth 4) -> status bit7=1 and bit4=1. Four host_rsp_rd pops drain the FIFO in order; host_rsp_data then reads 0.
6. Assert rst_n low during the cycle after a CMD_POP grant -> rvalid stays 0, status=8'h01 after release.

Source files
------------

// File: rtl/obi_host_mailbox.sv
// Host/X-HEEP mailbox: host command FIFO popped over OBI, OBI-pushed response FIFO
// read by the host, section-address register and sticky error flags with per-flag clears.
module obi_host_mailbox #(
    parameter int pDATA_WIDTH = 32,
    parameter int pCMD_DEPTH  = 8,
    parameter int pRSP_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_cmd_wr,
    input  logic [pDATA_WIDTH-1:0] host_cmd_data,
    input  logic                   host_addr_wr,
    input  logic [pDATA_WIDTH-1:0] host_addr_data,
    input  logic                   host_rsp_rd,
    output logic [pDATA_WIDTH-1:0] host_rsp_data,
    input  logic [3:0]             host_flag_clr,
    output logic [7:0]             status,
    input  logic                   req,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   gnt,
    output logic                   rvalid,
    output logic [31:0]            rdata
);

    localparam int CAW = $clog2(pCMD_DEPTH);
    localparam int RAW = $clog2(pRSP_DEPTH);
    localparam logic [CAW:0] CMD_MAX = (CAW+1)'(pCMD_DEPTH);
    localparam logic [RAW:0] RSP_MAX = (RAW+1)'(pRSP_DEPTH);

    localparam logic [2:0] OFF_CMD_POP   = 3'd0;
    localparam logic [2:0] OFF_SEC_ADDR  = 3'd1;
    localparam logic [2:0] OFF_STATUS    = 3'd2;
    localparam logic [2:0] OFF_RSP_PUSH  = 3'd3;
    localparam logic [2:0] OFF_CMD_COUNT = 3'd4;

    logic [pDATA_WIDTH-1:0] cmd_mem [pCMD_DEPTH];
    logic [CAW-1:0]         cmd_wptr, cmd_rptr;
    logic [CAW:0]           cmd_cnt;

    logic [pDATA_WIDTH-1:0] rsp_mem [pRSP_DEPTH];
    logic [RAW-1:0]         rsp_wptr, rsp_rptr;
    logic [RAW:0]           rsp_cnt;

    logic [pDATA_WIDTH-1:0] sec_addr;
    logic                   addr_valid;
    logic                   cmd_ovf, cmd_udf, rsp_ovf;

    logic [2:0]  off;
    logic        rd_req, wr_req;
    logic        cmd_empty, cmd_full, rsp_empty, rsp_full;
    logic        cmd_pop_req, cmd_pop_ok, cmd_push_ok, cmd_ovf_set, cmd_udf_set;
    logic        rsp_push_req, rsp_push_ok, rsp_pop_ok, rsp_ovf_set;
    logic        sec_rd;
    logic [31:0] be_mask;
    logic [31:0] rd_val;

    assign off    = addr[4:2];
    assign rd_req = req & ~we;
    assign wr_req = req & we;
    assign gnt    = req;

    assign cmd_empty = (cmd_cnt == '0);
    assign cmd_full  = (cmd_cnt == CMD_MAX);
    assign rsp_empty = (rsp_cnt == '0);
    assign rsp_full  = (rsp_cnt == RSP_MAX);

    // A pop frees a slot in the same cycle, so a push into a full FIFO only
    // overflows when no successful pop accompanies it.
    assign cmd_pop_req = rd_req && (off == OFF_CMD_POP);
    assign cmd_pop_ok  = cmd_pop_req && !cmd_empty;
    assign cmd_udf_set = cmd_pop_req && cmd_empty;
    assign cmd_push_ok = host_cmd_wr && (!cmd_full || cmd_pop_ok);
    assign cmd_ovf_set = host_cmd_wr && cmd_full && !cmd_pop_ok;

    assign rsp_push_req = wr_req && (off == OFF_RSP_PUSH);
    assign rsp_pop_ok   = host_rsp_rd && !rsp_empty;
    assign rsp_push_ok  = rsp_push_req && (!rsp_full || rsp_pop_ok);
    assign rsp_ovf_set  = rsp_push_req && rsp_full && !rsp_pop_ok;

    assign sec_rd  = rd_req && (off == OFF_SEC_ADDR);
    assign be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign status = {rsp_ovf, cmd_udf, cmd_ovf, rsp_full, !rsp_empty,
                     addr_valid, cmd_full, cmd_empty};

    assign host_rsp_data = rsp_empty ? '0 : rsp_mem[rsp_rptr];

    always_comb begin
        rd_val = '0;
        if (rd_req) begin
            case (off)
                OFF_CMD_POP:   rd_val = cmd_empty ? '0 : 32'(cmd_mem[cmd_rptr]);
                OFF_SEC_ADDR:  rd_val = 32'(sec_addr);
                OFF_STATUS:    rd_val = {24'b0, status};
                OFF_CMD_COUNT: rd_val = 32'(cmd_cnt);
                default:       rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push_ok) cmd_mem[cmd_wptr] <= host_cmd_data;
        if (rsp_push_ok) rsp_mem[rsp_wptr] <= pDATA_WIDTH'(wdata & be_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            cmd_cnt  <= '0;
            rsp_wptr <= '0;
            rsp_rptr <= '0;
            rsp_cnt  <= '0;
        end else begin
            if (cmd_push_ok) cmd_wptr <= cmd_wptr + 1'b1;
            if (cmd_pop_ok)  cmd_rptr <= cmd_rptr + 1'b1;
            case ({cmd_push_ok, cmd_pop_ok})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: cmd_cnt <= cmd_cnt;
            endcase
            if (rsp_push_ok) rsp_wptr <= rsp_wptr + 1'b1;
            if (rsp_pop_ok)  rsp_rptr <= rsp_rptr + 1'b1;
            case ({rsp_push_ok, rsp_pop_ok})
                2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
                2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end

    // Set events are OR-ed in after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_addr   <= '0;
            addr_valid <= 1'b0;
            cmd_ovf    <= 1'b0;
            cmd_udf    <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            if (host_addr_wr) sec_addr <= host_addr_data;
            addr_valid <= (addr_valid & ~host_flag_clr[3] & ~sec_rd) | host_addr_wr;
            cmd_ovf    <= (cmd_ovf & ~host_flag_clr[0]) | cmd_ovf_set;
            cmd_udf    <= (cmd_udf & ~host_flag_clr[1]) | cmd_udf_set;
            rsp_ovf    <= (rsp_ovf & ~host_flag_clr[2]) | rsp_ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= req;
            rdata  <= rd_val;
        end
    end

endmodule
